// File: rtl/div_ctrl_pkg.sv
// div_ctrl shared types: controller state encoding and
// the divide-by-zero quotient constant.
package div_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_ctrl_if.sv
// Pipeline-to-divide-controller request handshake.
// Transfer happens when op_valid & op_ready.
interface div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic             op_ready;
    logic             op_signed;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;

    modport master (
        output op_valid, op_signed, op_x, op_y,
        input  op_ready
    );

    modport slave (
        input  op_valid, op_signed, op_x, op_y,
        output op_ready
    );
endinterface

// File: rtl/div_ctrl_hilo_reg.sv
// HI/LO register pair; a divide result beats MTHI/MTLO
// when both write on the same edge.
module hilo_reg
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             div_clk,
    input  logic             resetn,
    input  logic             div_we,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] mt_wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    always_ff @(posedge div_clk) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (div_we) begin
            hi <= div_hi;
            lo <= div_lo;
        end else begin
            if (mthi_we) hi <= mt_wdata;
            if (mtlo_we) lo <= mt_wdata;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// EX-stage divide issue controller and HI/LO owner.
// Optional DIV_ZERO_FAST_EN: divide by zero bypasses core.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             div_clk,
    input  logic             resetn,
    div_ctrl_if.slave        op,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] mt_wdata,
    output logic [WIDTH-1:0] hi_rdata,
    output logic [WIDTH-1:0] lo_rdata,
    output logic             core_div,
    output logic             core_signed,
    output logic [WIDTH-1:0] core_x,
    output logic [WIDTH-1:0] core_y,
    input  logic [WIDTH-1:0] core_s,
    input  logic [WIDTH-1:0] core_r,
    input  logic             core_complete
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             div0_take;
    logic             res_take;
    logic             div_we;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    assign accept = (state == S_IDLE) && op.op_valid;

`ifdef DIV_ZERO_FAST_EN
    assign div0_take = accept && (op.op_y == '0);
`else
    assign div0_take = 1'b0;
`endif

    assign res_take = (state == S_WAIT) && core_complete && !flush;
    assign div_we   = res_take || div0_take;
    assign div_hi   = div0_take ? op.op_x : core_r;
    assign div_lo   = div0_take ? DIV0_LO : core_s;

    always_ff @(posedge div_clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Core cannot abort: a flushed divide drains its result.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (div0_take)   state_nxt = S_DONE;
                else if (accept) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_nxt = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (flush && core_complete) state_nxt = S_IDLE;
                else if (flush)             state_nxt = S_DRAIN;
                else if (core_complete)     state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_DRAIN: begin
                if (core_complete) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        op.op_ready = 1'b0;
        core_div    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (state)
            S_IDLE: begin
                op.op_ready = 1'b1;
                busy        = 1'b0;
            end
            S_LAUNCH: core_div = 1'b1;
            S_DONE:   done     = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge div_clk) begin
        if (!resetn) begin
            core_signed <= 1'b0;
            core_x      <= '0;
            core_y      <= '0;
        end else if (accept) begin
            core_signed <= op.op_signed;
            core_x      <= op.op_x;
            core_y      <= op.op_y;
        end
    end

    hilo_reg #(
        .WIDTH (WIDTH)
    ) u_hilo (
        .div_clk  (div_clk),
        .resetn   (resetn),
        .div_we   (div_we),
        .div_hi   (div_hi),
        .div_lo   (div_lo),
        .mthi_we  (mthi_we),
        .mtlo_we  (mtlo_we),
        .mt_wdata (mt_wdata),
        .hi       (hi_rdata),
        .lo       (lo_rdata)
    );

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a fixed-latency
// divider core model (complete sticky until next launch).
module tb_div_ctrl;

    logic        div_clk;
    logic        resetn;
    logic        flush;
    logic        busy;
    logic        done;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] mt_wdata;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;
    logic        core_div;
    logic        core_signed;
    logic [31:0] core_x;
    logic [31:0] core_y;
    logic [31:0] core_s;
    logic [31:0] core_r;
    logic        core_complete;

    int checks = 0;
    int errors = 0;

    div_ctrl_if #(.WIDTH(32)) op_if ();

    div_ctrl #(
        .WIDTH (32)
    ) dut (
        .div_clk       (div_clk),
        .resetn        (resetn),
        .op            (op_if),
        .flush         (flush),
        .busy          (busy),
        .done          (done),
        .mthi_we       (mthi_we),
        .mtlo_we       (mtlo_we),
        .mt_wdata      (mt_wdata),
        .hi_rdata      (hi_rdata),
        .lo_rdata      (lo_rdata),
        .core_div      (core_div),
        .core_signed   (core_signed),
        .core_x        (core_x),
        .core_y        (core_y),
        .core_s        (core_s),
        .core_r        (core_r),
        .core_complete (core_complete)
    );

    initial div_clk = 1'b0;
    always #5 div_clk = ~div_clk;

    // Core model: launch at end of A+1, complete seen in A+34.
    logic [5:0]  ccnt;
    logic [31:0] m_s;
    logic [31:0] m_r;

    always @(posedge div_clk) begin
        if (!resetn) begin
            ccnt <= 6'd0;
        end else if (core_div) begin
            ccnt <= 6'd1;
            if (core_y == 32'd0) begin
                m_s <= 32'hFFFF_FFFF;
                m_r <= core_x;
            end else if (core_signed) begin
                m_s <= $signed(core_x) / $signed(core_y);
                m_r <= $signed(core_x) % $signed(core_y);
            end else begin
                m_s <= core_x / core_y;
                m_r <= core_x % core_y;
            end
        end else if (ccnt != 6'd0 && ccnt < 6'd33) begin
            ccnt <= ccnt + 6'd1;
        end
    end

    assign core_complete = (ccnt == 6'd33);
    assign core_s        = m_s;
    assign core_r        = m_r;

    task automatic accept_op(input logic s,
                             input logic [31:0] x,
                             input logic [31:0] y);
        @(negedge div_clk);
        op_if.op_valid  = 1'b1;
        op_if.op_signed = s;
        op_if.op_x      = x;
        op_if.op_y      = y;
        @(posedge div_clk);
        #1 op_if.op_valid = 1'b0;
    endtask

    task automatic mt_write(input logic h, input logic l,
                            input logic [31:0] d);
        @(negedge div_clk);
        mthi_we  = h;
        mtlo_we  = l;
        mt_wdata = d;
        @(posedge div_clk);
        #1;
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge div_clk);
        #1 resetn = 1'b1;
        @(negedge div_clk);
        checks++;
        if (op_if.op_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", op_if.op_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0 || core_div !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes done=%b div=%b want 0 0",
                     done, core_div);
        end
        checks++;
        if (hi_rdata !== 32'd0 || lo_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_hilo hi=%h lo=%h want 0 0",
                     hi_rdata, lo_rdata);
        end
        checks++;
        if (core_x !== 32'd0 || core_y !== 32'd0) begin
            errors++;
            $display("FAIL reset_ops x=%h y=%h want 0 0",
                     core_x, core_y);
        end
    endtask

    task automatic test_divu();
        int done_at = -1;
        int ndone = 0;
        int ndiv = 0;
        int div_at = -1;
        logic [31:0] hi_v = 'x;
        logic [31:0] lo_v = 'x;
        logic [31:0] x20 = 'x;
        logic [31:0] y20 = 'x;
        accept_op(1'b0, 32'd100, 32'd7);
        for (int k = 1; k <= 40; k++) begin
            @(negedge div_clk);
            if (core_div) begin
                ndiv++;
                div_at = k;
            end
            if (k == 20) begin
                x20 = core_x;
                y20 = core_y;
            end
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = k;
                    hi_v = hi_rdata;
                    lo_v = lo_rdata;
                end
            end
        end
        checks++;
        if (done_at != 35 || ndone != 1) begin
            errors++;
            $display("FAIL divu_done at=%0d n=%0d want 35 1",
                     done_at, ndone);
        end
        checks++;
        if (ndiv != 1 || div_at != 1) begin
            errors++;
            $display("FAIL divu_core_div n=%0d at=%0d want 1 1",
                     ndiv, div_at);
        end
        checks++;
        if (lo_v !== 32'd14 || hi_v !== 32'd2) begin
            errors++;
            $display("FAIL divu_result lo=%h hi=%h want e 2",
                     lo_v, hi_v);
        end
        checks++;
        if (x20 !== 32'd100 || y20 !== 32'd7) begin
            errors++;
            $display("FAIL divu_hold x=%h y=%h want 64 7",
                     x20, y20);
        end
    endtask

    task automatic test_divs();
        int done_at = -1;
        logic [31:0] hi_v = 'x;
        logic [31:0] lo_v = 'x;
        accept_op(1'b1, 32'hFFFF_FF9C, 32'd7);
        for (int k = 1; k <= 40; k++) begin
            @(negedge div_clk);
            if (done && done_at < 0) begin
                done_at = k;
                hi_v = hi_rdata;
                lo_v = lo_rdata;
            end
        end
        checks++;
        if (done_at != 35) begin
            errors++;
            $display("FAIL divs_done at=%0d want 35", done_at);
        end
        checks++;
        if (lo_v !== 32'hFFFF_FFF2 || hi_v !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL divs_result lo=%h hi=%h want fffffff2 fffffffe",
                     lo_v, hi_v);
        end
    endtask

    task automatic test_back_to_back();
        int nready = 0;
        int ndone = 0;
        int d1 = -1;
        int d2 = -1;
        logic rdy36 = 1'b0;
        logic [31:0] lo2 = 'x;
        logic [31:0] hi2 = 'x;
        @(negedge div_clk);
        op_if.op_valid  = 1'b1;
        op_if.op_signed = 1'b0;
        op_if.op_x      = 32'd77;
        op_if.op_y      = 32'd10;
        @(posedge div_clk);
        #1;
        op_if.op_x = 32'd1000;
        op_if.op_y = 32'd33;
        for (int k = 1; k <= 80; k++) begin
            @(negedge div_clk);
            if (k <= 35 && op_if.op_ready) nready++;
            if (k == 36) rdy36 = op_if.op_ready;
            if (done) begin
                ndone++;
                if (d1 < 0) d1 = k;
                else if (d2 < 0) begin
                    d2 = k;
                    lo2 = lo_rdata;
                    hi2 = hi_rdata;
                end
            end
            if (k == 36) begin
                @(posedge div_clk);
                #1 op_if.op_valid = 1'b0;
            end
        end
        checks++;
        if (nready != 0) begin
            errors++;
            $display("FAIL b2b_ready_low cycles_high=%0d want 0", nready);
        end
        checks++;
        if (rdy36 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_a36 got %b want 1", rdy36);
        end
        checks++;
        if (d1 != 35 || d2 != 71 || ndone != 2) begin
            errors++;
            $display("FAIL b2b_done d1=%0d d2=%0d n=%0d want 35 71 2",
                     d1, d2, ndone);
        end
        checks++;
        if (lo2 !== 32'd30 || hi2 !== 32'd10) begin
            errors++;
            $display("FAIL b2b_result lo=%h hi=%h want 1e a", lo2, hi2);
        end
    endtask

    task automatic test_flush();
        int ndone = 0;
        int idle_at = -1;
        int done_at = -1;
        logic [31:0] lo_v = 'x;
        logic [31:0] hi_v = 'x;
        mt_write(1'b1, 1'b1, 32'h1234);
        @(negedge div_clk);
        checks++;
        if (hi_rdata !== 32'h1234 || lo_rdata !== 32'h1234) begin
            errors++;
            $display("FAIL flush_preload hi=%h lo=%h want 1234 1234",
                     hi_rdata, lo_rdata);
        end
        accept_op(1'b0, 32'd50, 32'd5);
        for (int k = 1; k <= 45; k++) begin
            @(negedge div_clk);
            if (done) ndone++;
            if (!busy && idle_at < 0) idle_at = k;
            if (k == 10) begin
                flush = 1'b1;
                @(posedge div_clk);
                #1 flush = 1'b0;
            end
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL flush_no_done n=%0d want 0", ndone);
        end
        checks++;
        if (idle_at != 35) begin
            errors++;
            $display("FAIL flush_busy_drop at=%0d want 35", idle_at);
        end
        checks++;
        if (hi_rdata !== 32'h1234 || lo_rdata !== 32'h1234) begin
            errors++;
            $display("FAIL flush_hilo hi=%h lo=%h want 1234 1234",
                     hi_rdata, lo_rdata);
        end
        accept_op(1'b0, 32'd9, 32'd2);
        for (int k = 1; k <= 40; k++) begin
            @(negedge div_clk);
            if (done && done_at < 0) begin
                done_at = k;
                lo_v = lo_rdata;
                hi_v = hi_rdata;
            end
        end
        checks++;
        if (done_at != 35 || lo_v !== 32'd4 || hi_v !== 32'd1) begin
            errors++;
            $display("FAIL flush_next at=%0d lo=%h hi=%h want 35 4 1",
                     done_at, lo_v, hi_v);
        end
    endtask

    task automatic test_mt_collision();
        logic [31:0] lo35 = 'x;
        logic [31:0] hi35 = 'x;
        accept_op(1'b0, 32'd100, 32'd7);
        for (int k = 1; k <= 40; k++) begin
            @(negedge div_clk);
            if (k == 35) begin
                lo35 = lo_rdata;
                hi35 = hi_rdata;
            end
            if (k == 34) begin
                mtlo_we  = 1'b1;
                mt_wdata = 32'hAAAA;
                @(posedge div_clk);
                #1 mtlo_we = 1'b0;
            end
        end
        checks++;
        if (lo35 !== 32'd14 || hi35 !== 32'd2) begin
            errors++;
            $display("FAIL mt_collide lo=%h hi=%h want e 2", lo35, hi35);
        end
        mt_write(1'b1, 1'b0, 32'h55);
        @(negedge div_clk);
        checks++;
        if (hi_rdata !== 32'h55 || lo_rdata !== 32'd14) begin
            errors++;
            $display("FAIL mthi_idle hi=%h lo=%h want 55 e",
                     hi_rdata, lo_rdata);
        end
    endtask

    task automatic test_div0();
        int done_at = -1;
        int ndiv = 0;
        int want_at;
        int want_div;
        logic [31:0] hi_v = 'x;
        logic [31:0] lo_v = 'x;
`ifdef DIV_ZERO_FAST_EN
        want_at  = 1;
        want_div = 0;
`else
        want_at  = 35;
        want_div = 1;
`endif
        accept_op(1'b1, 32'h8000_0000, 32'd0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge div_clk);
            if (core_div) ndiv++;
            if (done && done_at < 0) begin
                done_at = k;
                hi_v = hi_rdata;
                lo_v = lo_rdata;
            end
        end
        checks++;
        if (done_at != want_at) begin
            errors++;
            $display("FAIL div0_done at=%0d want %0d", done_at, want_at);
        end
        checks++;
        if (ndiv != want_div) begin
            errors++;
            $display("FAIL div0_core_div n=%0d want %0d", ndiv, want_div);
        end
        checks++;
        if (hi_v !== 32'h8000_0000 || lo_v !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div0_result hi=%h lo=%h want 80000000 ffffffff",
                     hi_v, lo_v);
        end
    endtask

    task automatic test_reset_mid();
        accept_op(1'b0, 32'd60, 32'd6);
        repeat (5) @(negedge div_clk);
        resetn = 1'b0;
        @(posedge div_clk);
        #1 resetn = 1'b1;
        @(negedge div_clk);
        checks++;
        if (busy !== 1'b0 || op_if.op_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_state busy=%b ready=%b want 0 1",
                     busy, op_if.op_ready);
        end
        checks++;
        if (hi_rdata !== 32'd0 || lo_rdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_hilo hi=%h lo=%h want 0 0",
                     hi_rdata, lo_rdata);
        end
    endtask

    initial begin
        resetn          = 1'b0;
        flush           = 1'b0;
        mthi_we         = 1'b0;
        mtlo_we         = 1'b0;
        mt_wdata        = 32'd0;
        op_if.op_valid  = 1'b0;
        op_if.op_signed = 1'b0;
        op_if.op_x      = 32'd0;
        op_if.op_y      = 32'd0;
        test_reset();
        test_divu();
        test_divs();
        test_back_to_back();
        test_flush();
        test_mt_collision();
        test_div0();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Issue controller and HI/LO holder for the EX stage of the 5-stage pipeline. Accepts DIV/DIVU requests from the pipeline over a valid/ready handshake and drives the iterative divider core's `div`/`div_signed`/`x`/`y` inputs. Collects `s`/`r` on `complete`, then writes LO/HI. Also owns MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width (only 32 supported)

Ports:
- `div_clk` in 1: clock
- `resetn` in 1: synchronous, active-low reset
- `op_valid` in 1: pipeline presents a divide
- `op_ready` out 1: controller accepts; transfer when `op_valid & op_ready`
- `op_signed` in 1: 1 = DIV, 0 = DIVU
- `op_x` in 32: dividend
- `op_y` in 32: divisor
- `flush` in 1: cancel in-flight divide (exception/ERET)
- `busy` out 1: divide in flight; pipeline stalls MFHI/MFLO/MTHI/MTLO/new DIV while high
- `done` out 1: one-cycle pulse when HI/LO updated by a divide
- `mthi_we`, `mtlo_we` in 1: HI/LO software writes
- `mt_wdata` in 32: MTHI/MTLO data
- `hi_rdata`, `lo_rdata` out 32: current HI (remainder) / LO (quotient)
- `core_div` out 1: start strobe to divider core
- `core_signed` out 1; `core_x`, `core_y` out 32: latched operands to core
- `core_s`, `core_r` in 32: core quotient/remainder
- `core_complete` in 1: core result valid

## Operation
- States: IDLE, LAUNCH, WAIT, DONE, DRAIN.
- IDLE: `op_ready=1`. On accept, latch `op_signed/op_x/op_y` into the core operand registers and go to LAUNCH.
- LAUNCH: `core_div=1` for exactly this cycle. Go to WAIT.
- WAIT: `core_div=0`. On `core_complete`, write LO←`core_s` and HI←`core_r`, then go to DONE.
- DONE: `done=1` for one cycle, then go to IDLE. This also guarantees one idle cycle so the core's stale `complete` clears before any relaunch.
- `busy=1` in LAUNCH, WAIT, DONE, DRAIN.
- `flush` in LAUNCH or WAIT: go to DRAIN. The core cannot abort, so the controller waits for `core_complete` and discards the result: HI/LO unchanged, no `done`. From DRAIN go to IDLE. `flush` in IDLE/DONE has no effect; a DONE write already made stands.
- `core_div` is never asserted outside LAUNCH. `core_x/core_y/core_signed` are held stable from LAUNCH until leaving WAIT/DRAIN.
- MTHI/MTLO write HI/LO at the clock edge. If a divide result is written in the same cycle, the divide result wins for both HI and LO.
- Reset: state IDLE; HI=LO=0; `core_x=core_y=0`; `core_div=0`; `done=0`; `busy=0`; `op_ready=1` on the first cycle after reset. Reset mid-divide returns to IDLE immediately. The core shares `resetn` and resets with it.

## Timing
- Accept at edge closing cycle A, LAUNCH is cycle A+1, core computes during A+2..A+33, and `core_complete` is seen in A+34.
- HI/LO are updated at the end of A+34. `done`/DONE in A+35; next accept possible at earliest in A+36 (IDLE).
- WAIT exits on `core_complete` and does not count cycles itself.
- `hi_rdata/lo_rdata` reflect the register contents directly: new values visible the cycle after the write edge.

## Configuration
- `DIV_ZERO_FAST_EN` defined: on accept with `op_y==0`, go directly to DONE without launching the core. HI←`op_x`, LO←32'hFFFFFFFF regardless of `op_signed`. `done` comes in A+1.
- Undefined: divide-by-zero takes the normal path. HI/LO take whatever the core returns, with full latency.

## Structure
- Package `div_ctrl_pkg`: state encoding (3-bit), `DIV0_LO` = 32'hFFFFFFFF.
- Sub-module `hilo_reg`: HI/LO register pair with div-over-MT write priority and synchronous reset.

## Test plan
- DIVU x=100, y=7 -> `done` at A+35; LO=14, HI=2; `core_div` high exactly one cycle.
- DIV x=-100 (0xFFFFFF9C), y=7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2).
- Back-to-back: second `op_valid` held high -> `op_ready` low A+1..A+35; second accept at A+36; second result correct.
- `flush` in cycle A+10 of DIVU 50/5, with HI=LO=0x1234 beforehand -> no `done`; HI/LO stay 0x1234; `busy` drops after core completes; next DIVU 9/2 gives LO=4, HI=1.
- MTLO 0xAAAA in the same cycle the divide result writes -> LO = quotient; MTHI 0x55 in IDLE -> HI=0x55 next cycle.
- With `DIV_ZERO_FAST_EN`: DIV x=0x80000000, y=0 -> `done` at A+1; HI=0x80000000, LO=0xFFFFFFFF; `core_div` never asserted.
